// File: rtl/fifo_sched_pkg.sv
// Shared types and defaults for the FIFO-to-memory burst scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } sched_state_t;

    localparam int unsigned DEF_BURST_LEN  = 16;
    localparam int unsigned DEF_BEAT_BYTES = 16;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sched_beat_cnt.sv
// Per-burst beat counter plus the beat_valid/beat_last pipeline for a FIFO without output register.
// Latency: beat_valid_o/beat_last_o follow rd_en_i by one cycle; beats_left_o/last_pop_o are combinational.
// Backpressure: none of its own; it counts whatever pops the parent issues.
// Ports: clk/rst; clr_i restarts the count; rd_en_i is the pop strobe;
//        beats_left_o = count below BURST_LEN; last_pop_o = this pop is the final beat.
module sched_beat_cnt
    import fifo_sched_pkg::*;
#(
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic rd_en_i,
    output logic beats_left_o,
    output logic last_pop_o,
    output logic beat_valid_o,
    output logic beat_last_o
);

    localparam int unsigned           CNT_W    = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]      CNT_END  = CNT_W'(BURST_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             valid_q;
    logic             last_q;

    assign beats_left_o = (cnt_q < CNT_END);
    assign last_pop_o   = rd_en_i && (cnt_q == LAST_IDX);
    assign beat_valid_o = valid_q;
    assign beat_last_o  = last_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (rd_en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FIFO data appears the cycle after the pop, so the valid/last flags are the pop delayed by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= rd_en_i;
            last_q  <= last_pop_o;
        end
    end

endmodule

// File: rtl/fifo_burst_sched.sv
// Drains a FIFO in fixed-length bursts toward a memory writer, stepping the burst address through a frame.
// Latency: burst_req one cycle after the start condition; pops begin the cycle after burst_gnt.
// Backpressure: waits in REQ for burst_gnt; pops pause (and underflow latches) while rd_empty is high.
// Ports: clk/rst; enable, frame_start control; rd_water_level/rd_empty from FIFO; fifo_rd_en pops;
//        burst_req/burst_gnt/burst_addr/burst_len to writer; beat_valid/beat_last qualify rd_data;
//        frame_done pulses at frame end; underflow is sticky.
module fifo_burst_sched
    import fifo_sched_pkg::*;
#(
    parameter int unsigned RD_DEPTH_WIDTH = 5,
    parameter int unsigned BURST_LEN      = DEF_BURST_LEN,
    parameter int unsigned FRAME_BEATS    = 1024,
    parameter int unsigned ADDR_W         = 28,
    parameter int unsigned BEAT_BYTES     = DEF_BEAT_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    frame_start,
    input  logic [RD_DEPTH_WIDTH:0] rd_water_level,
    input  logic                    rd_empty,
    output logic                    fifo_rd_en,
    output logic                    burst_req,
    input  logic                    burst_gnt,
    output logic [ADDR_W-1:0]       burst_addr,
    output logic [7:0]              burst_len,
    output logic                    beat_valid,
    output logic                    beat_last,
    output logic                    frame_done,
    output logic                    underflow
);

    localparam int unsigned             FCNT_W    = cnt_width(FRAME_BEATS);
    localparam logic [ADDR_W-1:0]       ADDR_STEP = ADDR_W'(BURST_LEN * BEAT_BYTES);
    localparam logic [FCNT_W-1:0]       FCNT_STEP = FCNT_W'(BURST_LEN);
    localparam logic [FCNT_W-1:0]       FCNT_END  = FCNT_W'(FRAME_BEATS);
    localparam logic [RD_DEPTH_WIDTH:0] LVL_MIN   = (RD_DEPTH_WIDTH + 1)'(BURST_LEN);

    sched_state_t      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic              pend_start_q;
    logic              burst_req_q;
    logic              frame_done_q;
    logic              underflow_q;

    logic              beats_left;
    logic              last_pop;
    logic              frame_end;
    logic              start_ok;

    // Pop is combinational so rd_empty and an async reset take effect within the same cycle.
    assign fifo_rd_en = (state_q == S_XFER) && beats_left && !rd_empty;
    assign frame_end  = (fcnt_q + FCNT_STEP) == FCNT_END;
    assign start_ok   = enable && (rd_water_level >= LVL_MIN);

    assign burst_req  = burst_req_q;
    assign burst_addr = addr_q;
    assign burst_len  = 8'(BURST_LEN - 1);
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

    sched_beat_cnt #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (state_q == S_DONE),
        .rd_en_i      (fifo_rd_en),
        .beats_left_o (beats_left),
        .last_pop_o   (last_pop),
        .beat_valid_o (beat_valid),
        .beat_last_o  (beat_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            fcnt_q       <= '0;
            pend_start_q <= 1'b0;
            burst_req_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if ((state_q == S_XFER) && beats_left && rd_empty) begin
                underflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    // A frame restart and a burst start in the same cycle both apply: REQ sees address 0.
                    if (frame_start) begin
                        addr_q <= '0;
                        fcnt_q <= '0;
                    end
                    if (start_ok) begin
                        state_q     <= S_REQ;
                        burst_req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (frame_start) begin
                        pend_start_q <= 1'b1;
                    end
                    if (burst_gnt) begin
                        state_q     <= S_XFER;
                        burst_req_q <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (frame_start) begin
                        pend_start_q <= 1'b1;
                    end
                    if (last_pop) begin
                        state_q      <= S_DONE;
                        frame_done_q <= frame_end;
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    pend_start_q <= 1'b0;
                    // A restart requested during the burst wins over the normal advance/wrap.
                    if (pend_start_q || frame_start || frame_end) begin
                        addr_q <= '0;
                        fcnt_q <= '0;
                    end else begin
                        addr_q <= addr_q + ADDR_STEP;
                        fcnt_q <= fcnt_q + FCNT_STEP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Self-checking bench for fifo_burst_sched: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: grant delay and FIFO empty are driven by the bench.
module tb_fifo_burst_sched;

    localparam int RDW = 5;
    localparam int BL  = 16;
    localparam int FB  = 1024;
    localparam int AW  = 28;
    localparam int BB  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          frame_start;
    logic [RDW:0]  rd_water_level;
    logic          rd_empty;
    logic          fifo_rd_en;
    logic          burst_req;
    logic          burst_gnt;
    logic [AW-1:0] burst_addr;
    logic [7:0]    burst_len;
    logic          beat_valid;
    logic          beat_last;
    logic          frame_done;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;
    bit gnt_rand = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_sched #(
        .RD_DEPTH_WIDTH (RDW),
        .BURST_LEN      (BL),
        .FRAME_BEATS    (FB),
        .ADDR_W         (AW),
        .BEAT_BYTES     (BB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .frame_start    (frame_start),
        .rd_water_level (rd_water_level),
        .rd_empty       (rd_empty),
        .fifo_rd_en     (fifo_rd_en),
        .burst_req      (burst_req),
        .burst_gnt      (burst_gnt),
        .burst_addr     (burst_addr),
        .burst_len      (burst_len),
        .beat_valid     (beat_valid),
        .beat_last      (beat_last),
        .frame_done     (frame_done),
        .underflow      (underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: where is the burst, how many beats of the frame are done ----
    bit            m_req, m_xfer, m_close, m_pend, m_uf, m_prev_rd, m_prev_last;
    int            m_pops;
    int            m_fbeats;
    logic          e_rd, e_fd;
    logic [AW-1:0] e_addr;

    // ---------------- monitor of actual DUT behaviour, for directed literal checks -----------------
    int            cyc = 0;
    int            grants = 0;
    int            cur_pops = 0;
    int            bv_cnt = 0;
    int            first_pop = 0;
    int            last_pop = 0;
    int            fd_cnt = 0;
    int            fd_grants = 0;
    logic [AW-1:0] addr_log[$];
    int            pops_log[$];
    int            lastpos_log[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_req = 0; m_xfer = 0; m_close = 0; m_pend = 0; m_uf = 0;
            m_prev_rd = 0; m_prev_last = 0; m_pops = 0; m_fbeats = 0;
            cur_pops = 0;
        end
        e_rd   = m_xfer && (m_pops < BL) && !rd_empty;
        e_addr = AW'(m_fbeats * BB);
        e_fd   = m_close && (m_fbeats + BL == FB);
        chk("fifo_rd_en", 64'(fifo_rd_en), 64'(e_rd));
        chk("burst_req",  64'(burst_req),  64'(m_req));
        chk("burst_addr", 64'(burst_addr), 64'(e_addr));
        chk("burst_len",  64'(burst_len),  64'(BL - 1));
        chk("beat_valid", 64'(beat_valid), 64'(m_prev_rd));
        chk("beat_last",  64'(beat_last),  64'(m_prev_last));
        chk("frame_done", 64'(frame_done), 64'(e_fd));
        chk("underflow",  64'(underflow),  64'(m_uf));
        if (!rst) begin
            if (burst_req && burst_gnt) begin
                addr_log.push_back(burst_addr);
                grants++;
                cur_pops = 0;
                bv_cnt = 0;
            end
            if (fifo_rd_en) begin
                cur_pops++;
                if (cur_pops == 1) first_pop = cyc;
                last_pop = cyc;
            end
            if (beat_valid) bv_cnt++;
            if (beat_last) begin
                pops_log.push_back(cur_pops);
                lastpos_log.push_back(bv_cnt);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_grants = grants;
            end
            // advance the model by one clock
            if (m_xfer && m_pops < BL && rd_empty) m_uf = 1;
            m_prev_last = e_rd && (m_pops == BL - 1);
            m_prev_rd   = e_rd;
            if (m_close) begin
                m_close = 0;
                if (m_pend || frame_start) m_fbeats = 0;
                else m_fbeats = (m_fbeats + BL) % FB;
                m_pend = 0;
            end else if (m_xfer) begin
                if (frame_start) m_pend = 1;
                if (e_rd) m_pops++;
                if (m_pops == BL) begin
                    m_xfer = 0;
                    m_close = 1;
                end
            end else if (m_req) begin
                if (frame_start) m_pend = 1;
                if (burst_gnt) begin
                    m_req = 0;
                    m_xfer = 1;
                    m_pops = 0;
                end
            end else begin
                if (frame_start) m_fbeats = 0;
                if (enable && int'(rd_water_level) >= BL) m_req = 1;
            end
        end
    end

    // Inputs change 2 time units after the active edge; frame_start is a one-cycle pulse.
    task automatic step();
        @(posedge clk);
        #2;
        burst_gnt   = burst_req && (gnt_rand ? ($urandom_range(0, 2) == 0) : 1'b1);
        frame_start = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int base, pl, fdb, mism, budget;

    initial begin
        rst = 1'b1; enable = 1'b0; frame_start = 1'b0; rd_empty = 1'b0;
        rd_water_level = '0; burst_gnt = 1'b0;
        step();
        step();
        #1;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_req",   64'(burst_req),  64'd0);
        chk("rst_addr",  64'(burst_addr), 64'd0);
        chk("rst_uf",    64'(underflow),  64'd0);
        chk("rst_len",   64'(burst_len),  64'd15);
        rst = 1'b0;

        // Level threshold, then a single burst with immediate grant.
        enable = 1'b1; rd_water_level = 15;
        base = grants; pl = pops_log.size();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lvl15_no_req", 64'(burst_req), 64'd0);
        end
        rd_water_level = 16;
        step();
        chk("lvl16_req", 64'(burst_req), 64'd1);
        enable = 1'b0;
        rd_water_level = 20;
        budget = 0;
        while (pops_log.size() == pl && budget < 100) begin step(); budget++; end
        chk("single_burst_done", 64'(pops_log.size() > pl), 64'd1);
        repeat (10) step();
        chk("single_grants", 64'(grants - base), 64'd1);
        if (addr_log.size() > base) chk("single_addr", 64'(addr_log[base]), 64'h0);
        if (pops_log.size() > pl) begin
            chk("single_pops",   64'(pops_log[pl]),    64'd16);
            chk("single_lastpos", 64'(lastpos_log[pl]), 64'd16);
        end
        chk("single_contig", 64'(last_pop - first_pop), 64'd15);

        // Empty for 3 cycles after the fifth beat.
        chk("uf_before", 64'(underflow), 64'd0);
        enable = 1'b1;
        base = grants; pl = pops_log.size();
        budget = 0;
        while (!(grants == base + 1 && cur_pops == 5) && budget < 200) begin step(); budget++; end
        chk("uf_reach_beat5", 64'(budget < 200), 64'd1);
        enable = 1'b0;
        rd_empty = 1'b1;
        repeat (3) step();
        rd_empty = 1'b0;
        budget = 0;
        while (pops_log.size() == pl && budget < 100) begin step(); budget++; end
        if (pops_log.size() > pl) chk("uf_pops", 64'(pops_log[pl]), 64'd16);
        chk("uf_span", 64'(last_pop - first_pop), 64'd18);
        repeat (3) step();
        chk("uf_sticky", 64'(underflow), 64'd1);

        // Reset in the middle of a burst.
        enable = 1'b1;
        base = grants;
        budget = 0;
        while (!(grants == base + 1 && cur_pops == 8) && budget < 200) begin step(); budget++; end
        chk("rst_reach_beat8", 64'(budget < 200), 64'd1);
        rst = 1'b1;
        enable = 1'b0;
        #1;
        chk("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("midrst_addr",  64'(burst_addr), 64'd0);
        chk("midrst_uf",    64'(underflow),  64'd0);
        chk("midrst_req",   64'(burst_req),  64'd0);
        step();
        rst = 1'b0;
        repeat (5) step();

        // One full frame plus one burst.
        reset_dut();
        enable = 1'b1; rd_water_level = 20;
        base = grants; fdb = fd_cnt;
        budget = 0;
        while (grants < base + 65 && budget < 3000) begin step(); budget++; end
        enable = 1'b0;
        chk("frame_reach_65", 64'(grants - base), 64'd65);
        repeat (25) step();
        if (addr_log.size() >= base + 65) begin
            mism = 0;
            for (int i = 0; i < 64; i++) if (addr_log[base + i] != AW'(i * 256)) mism++;
            chk("frame_addr_seq", 64'(mism), 64'd0);
            chk("frame_addr_last", 64'(addr_log[base + 63]), 64'h3F00);
            chk("frame_addr_wrap", 64'(addr_log[base + 64]), 64'h0);
        end
        chk("frame_done_cnt", 64'(fd_cnt - fdb), 64'd1);
        chk("frame_done_pos", 64'(fd_grants - base), 64'd64);

        // Frame restart while the 0x500 burst is transferring.
        reset_dut();
        enable = 1'b1;
        base = grants; pl = pops_log.size();
        budget = 0;
        while (!(grants == base + 6 && cur_pops == 3) && budget < 500) begin step(); budget++; end
        chk("fs_reach", 64'(budget < 500), 64'd1);
        frame_start = 1'b1;
        step();
        budget = 0;
        while (grants < base + 7 && budget < 200) begin step(); budget++; end
        enable = 1'b0;
        repeat (25) step();
        if (addr_log.size() >= base + 7) begin
            chk("fs_addr_cur",  64'(addr_log[base + 5]), 64'h500);
            chk("fs_addr_next", 64'(addr_log[base + 6]), 64'h0);
        end
        if (pops_log.size() >= pl + 6) chk("fs_burst_pops", 64'(pops_log[pl + 5]), 64'd16);

        // Randomized traffic checked cycle by cycle against the model.
        reset_dut();
        gnt_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            step();
            rst = 1'b0;
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) rd_water_level = (RDW + 1)'($urandom_range(0, 32));
            rd_empty = ($urandom_range(0, 6) == 0);
            frame_start = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_sched.md
FIFO_BURST_SCHED -- requirements
Module: fifo_burst_sched

Interface
REQ-001 SHALL have parameter RD_DEPTH_WIDTH, default 5, FIFO read-side depth exponent (level width RD_DEPTH_WIDTH+1).
REQ-002 SHALL have parameter BURST_LEN, default 16, beats per burst (1..2**RD_DEPTH_WIDTH).
REQ-003 SHALL have parameter FRAME_BEATS, default 1024, beats per frame (integer multiple of BURST_LEN).
REQ-004 SHALL have parameter ADDR_W, default 28, burst address width; parameter BEAT_BYTES, default 16, address increment per beat.
REQ-005 Ports, one per line:
- clk  in  1  single clock, FIFO read clock domain
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  level, permits new bursts
- frame_start  in  1  pulse, restart frame at base address 0
- rd_water_level  in  RD_DEPTH_WIDTH+1  FIFO read-side fill level
- rd_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop strobe
- burst_req  out  1  burst request to memory writer
- burst_gnt  in  1  one-cycle grant for burst_req
- burst_addr  out  ADDR_W  byte address of current burst
- burst_len  out  8  BURST_LEN-1, constant
- beat_valid  out  1  FIFO rd_data valid this cycle
- beat_last  out  1  qualifies final beat of burst
- frame_done  out  1  one-cycle pulse after last beat of frame
- underflow  out  1  sticky error flag

Function
REQ-006 SHALL implement FSM IDLE, REQ, XFER, DONE.
REQ-007 IDLE->REQ when enable=1 and rd_water_level >= BURST_LEN; otherwise stay IDLE.
REQ-008 REQ: burst_req=1, burst_addr stable; ->XFER on the cycle after burst_gnt=1; burst_req drops in the grant cycle.
REQ-009 XFER: fifo_rd_en=1 every cycle while beat counter < BURST_LEN and rd_empty=0; counter increments per asserted fifo_rd_en.
REQ-010 beat_valid SHALL be fifo_rd_en delayed one cycle (FIFO without output register); beat_last = beat_valid of beat BURST_LEN-1.
REQ-011 XFER->DONE in the cycle after beat BURST_LEN-1 is popped; DONE->IDLE unconditionally after one cycle.
REQ-012 In DONE: burst_addr += BURST_LEN*BEAT_BYTES; frame beat counter += BURST_LEN.
REQ-013 When the frame beat counter reaches FRAME_BEATS, SHALL assert frame_done one cycle in DONE, reset burst_addr and frame counter to 0 (wrap).
REQ-014 rd_empty=1 during XFER with beats outstanding: SHALL hold fifo_rd_en=0, set underflow=1 (sticky until rst), resume popping when rd_empty=0.
REQ-015 enable deasserted mid-REQ or mid-XFER: burst SHALL complete; no new burst starts.
REQ-016 frame_start in IDLE: burst_addr and frame counter cleared next cycle. In REQ/XFER/DONE: latched, applied on entry to IDLE, overriding REQ-013 wrap.
REQ-017 frame_start and the IDLE->REQ condition in the same cycle: clear applied first, REQ entered with burst_addr=0.
REQ-018 Address arithmetic SHALL be modulo 2**ADDR_W.

Reset
REQ-019 rst=1 SHALL force state IDLE, all outputs 0 except burst_len, counters and burst_addr 0, underflow 0, pending frame_start cleared.
REQ-020 Reset mid-XFER SHALL abort immediately; no further fifo_rd_en after rst asserts.

Structure
REQ-021 State encoding typedef and BURST_LEN/BEAT_BYTES defaults SHALL live in shared package fifo_sched_pkg.
REQ-022 One sub-module, sched_beat_cnt (beat counter, beat_valid/beat_last pipeline), SHALL be instantiated; remainder flat.

Verification
REQ-023 level=20, enable=1, immediate gnt -> one burst, 16 fifo_rd_en cycles, addr 0x0, beat_last on 16th beat_valid.
REQ-024 level held >=16 for 64 bursts -> addresses 0x0,0x100..0x3F00; frame_done once after 64th burst; next burst_addr 0x0.
REQ-025 rd_empty=1 for 3 cycles after beat 5 -> popping paused 3 cycles, 16 beats total, underflow=1.
REQ-026 frame_start during XFER at addr 0x500 -> burst completes at 0x500; next burst_addr 0x0.
REQ-027 rst asserted at beat 8 -> fifo_rd_en=0 same cycle, state IDLE, burst_addr 0, underflow 0.
REQ-028 level=15, enable=1 -> burst_req stays 0; level 16 -> burst_req=1 next cycle.
